// File: rtl/output_reg_ctrl.sv
// ============================================================================
// Module   : output_reg_ctrl
// Purpose  : Arbiter/sequencer for the 256-bit output register write/read path.
// Options  : OUTREG_CTRL_READBACK_EN adds a read-back VERIFY step after writes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module output_reg_ctrl #(
  parameter int DATA_W    = 256,
  parameter int READ_HOLD = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        wr_req,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic [DATA_W-1:0] wr_data1,
  output logic [1:0]        wr_ack,
  input  logic              rd_req,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              reg_write_data,
  output logic              reg_read_data,
  output logic [DATA_W-1:0] reg_data_to_write,
  input  logic [DATA_W-1:0] reg_data,
  output logic              busy,
  output logic              verify_err
);

  localparam int            HOLD_W    = (READ_HOLD > 1) ? $clog2(READ_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(READ_HOLD - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] WRITE  = 3'd1;
  localparam logic [2:0] READ   = 3'd2;
  localparam logic [2:0] DONE   = 3'd3;
  localparam logic [2:0] VERIFY = 3'd4;

  logic [2:0]        state;
  logic              rr_ptr;
  logic              read_last;
  logic              grant;
  logic              op_write;
  logic [HOLD_W-1:0] hold_cnt;

  logic any_wr;
  logic take_read;
  logic pick;
  logic hold_done;

  // A pending read yields once to a waiting writer so neither side starves.
  always_comb begin
    any_wr    = |wr_req;
    take_read = rd_req && !(read_last && any_wr);
    pick      = (wr_req == 2'b11) ? rr_ptr : wr_req[1];
    hold_done = (hold_cnt == HOLD_LAST);
  end

`ifdef OUTREG_CTRL_READBACK_EN
  logic verify_err_r;
  assign verify_err = verify_err_r;
`else
  assign verify_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      rr_ptr            <= 1'b0;
      read_last         <= 1'b0;
      grant             <= 1'b0;
      op_write          <= 1'b0;
      hold_cnt          <= '0;
      rd_data           <= '0;
      reg_data_to_write <= '0;
`ifdef OUTREG_CTRL_READBACK_EN
      verify_err_r      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (take_read) begin
            state     <= READ;
            hold_cnt  <= '0;
            read_last <= 1'b1;
            op_write  <= 1'b0;
          end else if (any_wr) begin
            state             <= WRITE;
            grant             <= pick;
            rr_ptr            <= ~pick;
            read_last         <= 1'b0;
            op_write          <= 1'b1;
            reg_data_to_write <= pick ? wr_data1 : wr_data0;
          end
        end
        WRITE: begin
`ifdef OUTREG_CTRL_READBACK_EN
          state    <= VERIFY;
          hold_cnt <= '0;
`else
          state    <= DONE;
`endif
        end
        READ: begin
          if (hold_done) begin
            rd_data <= reg_data;
            state   <= DONE;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
`ifdef OUTREG_CTRL_READBACK_EN
        VERIFY: begin
          if (hold_done) begin
            if (reg_data != reg_data_to_write) verify_err_r <= 1'b1;
            state <= DONE;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    reg_write_data = (state == WRITE);
    reg_read_data  = (state == READ) || (state == VERIFY);
    busy           = (state != IDLE);
    rd_valid       = (state == DONE) && !op_write;
    wr_ack         = 2'b00;
    if ((state == DONE) && op_write) wr_ack = grant ? 2'b10 : 2'b01;
  end

endmodule

`default_nettype wire
